// File: rtl/readout_rx_pkg.sv
// Shared types and constants for the readout I/Q window integrator.
// Holds the FSM state type, configuration register map and reset defaults.
package readout_rx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        INTEG = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam logic [1:0] CFG_ADDR_LOG2_WIN = 2'd0;
    localparam logic [1:0] CFG_ADDR_NUM_WIN  = 2'd1;
    localparam logic [1:0] CFG_ADDR_OFFSET_I = 2'd2;
    localparam logic [1:0] CFG_ADDR_OFFSET_Q = 2'd3;

    localparam logic [3:0] LOG2_WIN_RST = 4'd4;
    localparam int         NUM_WIN_RST  = 1;

    // Window exponents beyond what the accumulator can hold are pinned to the maximum.
    function automatic logic [3:0] clamp_log2(input logic [3:0] req, input int max_l);
        if (int'(req) > max_l) begin
            return 4'(max_l);
        end
        return req;
    endfunction

endpackage

// File: rtl/readout_rx_iq_integ_lane.sv
// One I or Q lane: accumulates samples, averages by shift, optional offset with saturation.
// The offset stage exists only when READOUT_RX_IQ_INTEG_OFFSET_EN is defined.
module readout_rx_iq_integ_lane #(
    parameter int DATA_WIDTH   = 16,
    parameter int LOG2_WIN_MAX = 8,
    parameter int ACC_WIDTH    = DATA_WIDTH + LOG2_WIN_MAX
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
    input  logic                         add,
    input  logic                         last,
    input  logic [3:0]                   log2_win,
`ifdef READOUT_RX_IQ_INTEG_OFFSET_EN
    input  logic signed [DATA_WIDTH-1:0] offset,
`endif
    input  logic signed [DATA_WIDTH-1:0] sample,
    output logic signed [DATA_WIDTH-1:0] avg
);

    localparam int PAD = ACC_WIDTH - DATA_WIDTH;

    logic signed [ACC_WIDTH-1:0]  acc;
    logic signed [ACC_WIDTH-1:0]  sum;
    logic signed [DATA_WIDTH-1:0] result;
    logic signed [DATA_WIDTH-1:0] lane_out;

`ifdef READOUT_RX_IQ_INTEG_OFFSET_EN
    localparam logic [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    logic [DATA_WIDTH:0] diff;
`endif

    // NOTE: every always_comb output is assigned on every path, so no latch is inferred.
    always_comb begin
        sum    = acc + {{PAD{sample[DATA_WIDTH-1]}}, sample};
        // The window average of in-range samples always fits, so the truncation is lossless.
        result = DATA_WIDTH'(sum >>> log2_win);
`ifdef READOUT_RX_IQ_INTEG_OFFSET_EN
        diff = {result[DATA_WIDTH-1], result} - {offset[DATA_WIDTH-1], offset};
        if (diff[DATA_WIDTH] != diff[DATA_WIDTH-1]) begin
            lane_out = diff[DATA_WIDTH] ? SAT_MIN : SAT_MAX;
        end else begin
            lane_out = diff[DATA_WIDTH-1:0];
        end
`else
        lane_out = result;
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc <= '0;
            avg <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (add) begin
            if (last) begin
                acc <= '0;
                avg <= lane_out;
            end else begin
                acc <= sum;
            end
        end
    end

endmodule

// File: rtl/readout_rx_iq_integrator.sv
// Readout receiver I/Q window integrator: FSM, counters, config registers, two lanes.
// Optional per-lane output offsets are enabled by READOUT_RX_IQ_INTEG_OFFSET_EN.
module readout_rx_iq_integrator
    import readout_rx_pkg::*;
#(
    parameter int DATA_WIDTH    = 16,
    parameter int LOG2_WIN_MAX  = 8,
    parameter int ACC_WIDTH     = DATA_WIDTH + LOG2_WIN_MAX,
    parameter int NUM_WIN_WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cfg_wr_en,
    input  logic [1:0]                   cfg_wr_addr,
    input  logic [15:0]                  cfg_wr_data,
    input  logic                         meas_start,
    input  logic                         valid_in,
    input  logic signed [DATA_WIDTH-1:0] i_in,
    input  logic signed [DATA_WIDTH-1:0] q_in,
    output logic                         start_count,
    output logic                         finish_count,
    output logic                         valid_out,
    output logic signed [DATA_WIDTH-1:0] i_out,
    output logic signed [DATA_WIDTH-1:0] q_out,
    output logic                         busy
);

    localparam int CW = LOG2_WIN_MAX + 1;

    state_t                     state;
    logic [3:0]                 log2_win;
    logic [NUM_WIN_WIDTH-1:0]   num_win;
    logic [NUM_WIN_WIDTH-1:0]   win_cnt;
    logic [LOG2_WIN_MAX-1:0]    sample_cnt;
    logic [NUM_WIN_WIDTH-1:0]   wr_num;
    logic [CW-1:0]              win_len_m1;
    logic                       sample_last;
    logic                       win_last;
    logic                       accept;
    logic                       clear;

`ifdef READOUT_RX_IQ_INTEG_OFFSET_EN
    logic signed [DATA_WIDTH-1:0] offset_i;
    logic signed [DATA_WIDTH-1:0] offset_q;
`endif

    assign wr_num      = NUM_WIN_WIDTH'(cfg_wr_data);
    assign win_len_m1  = (CW'(1) << log2_win) - CW'(1);
    assign sample_last = ({1'b0, sample_cnt} == win_len_m1);
    assign win_last    = (win_cnt == num_win - NUM_WIN_WIDTH'(1));
    assign accept      = valid_in && (state == INTEG);
    assign clear       = meas_start && (state == IDLE);
    assign busy        = (state != IDLE);

    // Configuration is frozen outside IDLE so a running measurement sees stable settings.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            log2_win <= clamp_log2(LOG2_WIN_RST, LOG2_WIN_MAX);
            num_win  <= NUM_WIN_WIDTH'(NUM_WIN_RST);
`ifdef READOUT_RX_IQ_INTEG_OFFSET_EN
            offset_i <= '0;
            offset_q <= '0;
`endif
        end else if (cfg_wr_en && (state == IDLE)) begin
            case (cfg_wr_addr)
                CFG_ADDR_LOG2_WIN: log2_win <= clamp_log2(cfg_wr_data[3:0], LOG2_WIN_MAX);
                CFG_ADDR_NUM_WIN:  num_win  <= (wr_num == '0) ? NUM_WIN_WIDTH'(1) : wr_num;
`ifdef READOUT_RX_IQ_INTEG_OFFSET_EN
                CFG_ADDR_OFFSET_I: offset_i <= DATA_WIDTH'(cfg_wr_data);
                CFG_ADDR_OFFSET_Q: offset_q <= DATA_WIDTH'(cfg_wr_data);
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            start_count  <= 1'b0;
            finish_count <= 1'b0;
            valid_out    <= 1'b0;
            sample_cnt   <= '0;
            win_cnt      <= '0;
        end else begin
            start_count  <= 1'b0;
            finish_count <= 1'b0;
            valid_out    <= 1'b0;
            case (state)
                IDLE: begin
                    if (meas_start) begin
                        state       <= INTEG;
                        start_count <= 1'b1;
                        sample_cnt  <= '0;
                        win_cnt     <= '0;
                    end
                end
                INTEG: begin
                    if (valid_in) begin
                        if (sample_last) begin
                            valid_out  <= 1'b1;
                            sample_cnt <= '0;
                            win_cnt    <= win_cnt + NUM_WIN_WIDTH'(1);
                            if (win_last) begin
                                state <= FLUSH;
                            end
                        end else begin
                            sample_cnt <= sample_cnt + LOG2_WIN_MAX'(1);
                        end
                    end
                end
                FLUSH: begin
                    // The final valid_out is visible during FLUSH; finish follows it.
                    state        <= IDLE;
                    finish_count <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    readout_rx_iq_integ_lane #(
        .DATA_WIDTH   (DATA_WIDTH),
        .LOG2_WIN_MAX (LOG2_WIN_MAX),
        .ACC_WIDTH    (ACC_WIDTH)
    ) u_lane_i (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .add      (accept),
        .last     (sample_last),
        .log2_win (log2_win),
`ifdef READOUT_RX_IQ_INTEG_OFFSET_EN
        .offset   (offset_i),
`endif
        .sample   (i_in),
        .avg      (i_out)
    );

    readout_rx_iq_integ_lane #(
        .DATA_WIDTH   (DATA_WIDTH),
        .LOG2_WIN_MAX (LOG2_WIN_MAX),
        .ACC_WIDTH    (ACC_WIDTH)
    ) u_lane_q (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .add      (accept),
        .last     (sample_last),
        .log2_win (log2_win),
`ifdef READOUT_RX_IQ_INTEG_OFFSET_EN
        .offset   (offset_q),
`endif
        .sample   (q_in),
        .avg      (q_out)
    );

endmodule

// File: tb/tb_readout_rx_iq_integrator.sv
// Table-driven, randomized bench for readout_rx_iq_integrator with a floor-division model.
// Offset expectations follow READOUT_RX_IQ_INTEG_OFFSET_EN when it is defined.
module tb_readout_rx_iq_integrator;

    logic               clk = 1'b0;
    logic               rst;
    logic               cfg_wr_en;
    logic [1:0]         cfg_wr_addr;
    logic [15:0]        cfg_wr_data;
    logic               meas_start;
    logic               valid_in;
    logic signed [15:0] i_in;
    logic signed [15:0] q_in;
    logic               start_count;
    logic               finish_count;
    logic               valid_out;
    logic signed [15:0] i_out;
    logic signed [15:0] q_out;
    logic               busy;

    readout_rx_iq_integrator #(
        .DATA_WIDTH    (16),
        .LOG2_WIN_MAX  (8),
        .ACC_WIDTH     (24),
        .NUM_WIN_WIDTH (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_wr_en    (cfg_wr_en),
        .cfg_wr_addr  (cfg_wr_addr),
        .cfg_wr_data  (cfg_wr_data),
        .meas_start   (meas_start),
        .valid_in     (valid_in),
        .i_in         (i_in),
        .q_in         (q_in),
        .start_count  (start_count),
        .finish_count (finish_count),
        .valid_out    (valid_out),
        .i_out        (i_out),
        .q_out        (q_out),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        longint i;
        longint q;
    } pair_t;

    typedef struct {
        bit          wr_cfg;
        logic [3:0]  l_cfg;
        logic [15:0] n_cfg;
        bit          gap;
        int          mode;       // 0 random, 1 all max, 2 all min, 3 fixed queue
        bit          disturb;
        int          exp_l;
        int          exp_pulses;
    } case_t;

    int     vectors = 0;
    int     miscompares = 0;
    pair_t  got_q[$];
    pair_t  exp_q[$];
    longint fixed_i[$];
    longint fixed_q[$];
    int     n_start, n_finish, last_vout_cyc, last_fin_cyc;
    longint m_off_i = 0;
    longint m_off_q = 0;

    task automatic check(input string name, input longint act, input longint exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (valid_out) begin
                got_q.push_back('{longint'(i_out), longint'(q_out)});
                last_vout_cyc = cyc;
                check("vout_fin_exclusive", longint'(finish_count), 0);
            end
            if (start_count) n_start++;
            if (finish_count) begin
                n_finish++;
                last_fin_cyc = cyc;
            end
        end
    end

    // Floor of sum / 2^l, then offset removal clipped to the 16-bit signed range.
    function automatic longint model_avg(input longint sum, input int l, input longint off);
        longint w = longint'(1) << l;
        longint q = sum / w;
        if ((sum % w) != 0 && sum < 0) q = q - 1;
        q = q - off;
        if (q > 32767) q = 32767;
        if (q < -32768) q = -32768;
        return q;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [15:0] d);
        cfg_wr_en   = 1'b1;
        cfg_wr_addr = a;
        cfg_wr_data = d;
        tick();
        cfg_wr_en   = 1'b0;
    endtask

    task automatic run_meas(input case_t c, input string tag);
        longint     si, sq, vi, vq;
        logic [15:0] r;
        int         last_smp_cyc;
        if (c.wr_cfg) begin
            cfg_write(2'd0, {12'd0, c.l_cfg});
            cfg_write(2'd1, c.n_cfg);
        end
        got_q.delete();
        exp_q.delete();
        n_start = 0; n_finish = 0; last_vout_cyc = -1; last_fin_cyc = -1; last_smp_cyc = -100;
        meas_start = 1'b1;
        tick();
        meas_start = 1'b0;
        check({tag, "_start_count"}, longint'(start_count), 1);
        check({tag, "_busy"}, longint'(busy), 1);
        for (int w = 0; w < c.exp_pulses; w++) begin
            si = 0; sq = 0;
            for (int s = 0; s < (1 << c.exp_l); s++) begin
                if (c.gap) begin
                    valid_in = 1'b0;
                    i_in = 16'($urandom);
                    q_in = 16'($urandom);
                    tick();
                end
                case (c.mode)
                    1: begin vi = 32767; vq = 32767; end
                    2: begin vi = -32768; vq = -32768; end
                    3: begin vi = fixed_i.pop_front(); vq = fixed_q.pop_front(); end
                    default: begin
                        r = 16'($urandom); vi = longint'($signed(r));
                        r = 16'($urandom); vq = longint'($signed(r));
                    end
                endcase
                valid_in = 1'b1;
                i_in = vi[15:0];
                q_in = vq[15:0];
                if (c.disturb && w == 0 && s == 3) begin
                    meas_start  = 1'b1;
                    cfg_wr_en   = 1'b1;
                    cfg_wr_addr = 2'd0;
                    cfg_wr_data = 16'd1;
                end
                last_smp_cyc = cyc;
                tick();
                meas_start = 1'b0;
                cfg_wr_en  = 1'b0;
                si += vi;
                sq += vq;
            end
            exp_q.push_back('{model_avg(si, c.exp_l, m_off_i), model_avg(sq, c.exp_l, m_off_q)});
        end
        valid_in = 1'b0;
        for (int k = 0; k < 10 && n_finish == 0; k++) tick();
        tick();
        tick();
        check({tag, "_finish_pulses"}, n_finish, 1);
        check({tag, "_start_pulses"}, n_start, 1);
        check({tag, "_busy_after"}, longint'(busy), 0);
        check({tag, "_vout_count"}, got_q.size(), exp_q.size());
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            check($sformatf("%s_i%0d", tag, k), got_q[k].i, exp_q[k].i);
            check($sformatf("%s_q%0d", tag, k), got_q[k].q, exp_q[k].q);
        end
        check({tag, "_vout_latency"}, last_vout_cyc - last_smp_cyc, 1);
        check({tag, "_finish_latency"}, last_fin_cyc - last_vout_cyc, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        case_t  cases[10];
        case_t  c_post;
        case_t  c_off;
        longint ti[12];

        cases[0] = '{0, 4'd0,  16'd0, 0, 3, 0, 4, 1};   // reset defaults, constant +100/-100
        cases[1] = '{1, 4'd2,  16'd3, 0, 3, 0, 2, 3};   // three windows of four
        cases[2] = '{1, 4'd3,  16'd2, 1, 0, 0, 3, 2};   // valid every other cycle
        cases[3] = '{1, 4'd3,  16'd2, 0, 0, 0, 3, 2};   // same config, contiguous
        cases[4] = '{1, 4'd5,  16'd2, 0, 0, 1, 5, 2};   // restart and cfg write mid-run
        cases[5] = '{0, 4'd0,  16'd0, 0, 0, 0, 5, 2};   // config must have survived
        cases[6] = '{1, 4'd0,  16'd5, 0, 0, 0, 0, 5};   // pass-through
        cases[7] = '{1, 4'd12, 16'd1, 0, 0, 0, 8, 1};   // exponent clamped
        cases[8] = '{1, 4'd4,  16'd0, 0, 1, 0, 4, 1};   // num_win 0 acts as 1, max samples
        cases[9] = '{1, 4'd1,  16'd2, 0, 2, 0, 1, 2};   // min samples
        c_post   = '{0, 4'd0,  16'd0, 0, 0, 0, 4, 1};
        c_off    = '{1, 4'd2,  16'd1, 0, 3, 0, 2, 1};

        rst = 1'b0; cfg_wr_en = 1'b0; cfg_wr_addr = '0; cfg_wr_data = '0;
        meas_start = 1'b0; valid_in = 1'b0; i_in = '0; q_in = '0;
        tick();
        tick();
        check("rst_i_out", longint'(i_out), 0);
        check("rst_q_out", longint'(q_out), 0);
        check("rst_valid_out", longint'(valid_out), 0);
        check("rst_start_count", longint'(start_count), 0);
        check("rst_finish_count", longint'(finish_count), 0);
        check("rst_busy", longint'(busy), 0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        for (int k = 0; k < 10; k++) begin
            if (k == 0) begin
                for (int s = 0; s < 16; s++) begin
                    fixed_i.push_back(100);
                    fixed_q.push_back(-100);
                end
            end
            if (k == 1) begin
                ti = '{1, 2, 3, 4, 4, 4, 4, 4, -8, -8, -8, -7};
                for (int s = 0; s < 12; s++) begin
                    fixed_i.push_back(ti[s]);
                    fixed_q.push_back(-ti[s]);
                end
            end
            run_meas(cases[k], $sformatf("c%0d", k));
            if (k == 0 && got_q.size() > 0) begin
                check("c0_i_100", got_q[0].i, 100);
                check("c0_q_m100", got_q[0].q, -100);
            end
            if (k == 1 && got_q.size() == 3) begin
                check("c1_i_2", got_q[0].i, 2);
                check("c1_i_4", got_q[1].i, 4);
                check("c1_i_m8", got_q[2].i, -8);
            end
        end

        // Reset in the middle of a 16-sample window.
        cfg_write(2'd0, 16'd4);
        cfg_write(2'd1, 16'd1);
        n_finish = 0;
        meas_start = 1'b1;
        tick();
        meas_start = 1'b0;
        for (int s = 0; s < 7; s++) begin
            valid_in = 1'b1;
            i_in = 16'($urandom);
            q_in = 16'($urandom);
            tick();
        end
        valid_in = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check("midrst_i_out", longint'(i_out), 0);
        check("midrst_q_out", longint'(q_out), 0);
        check("midrst_valid_out", longint'(valid_out), 0);
        check("midrst_start_count", longint'(start_count), 0);
        check("midrst_finish_count", longint'(finish_count), 0);
        check("midrst_busy", longint'(busy), 0);
        tick();
        tick();
        check("midrst_busy_held", longint'(busy), 0);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        check("midrst_no_finish", n_finish, 0);
        check("midrst_idle", longint'(busy), 0);
        run_meas(c_post, "post_rst");

        // Offset write; discarded unless the offset feature is built in.
        cfg_write(2'd2, 16'h8000);
        cfg_write(2'd3, 16'h0000);
`ifdef READOUT_RX_IQ_INTEG_OFFSET_EN
        m_off_i = -32768;
        m_off_q = 0;
`endif
        for (int s = 0; s < 4; s++) begin
            fixed_i.push_back(32000);
            fixed_q.push_back(1000);
        end
        run_meas(c_off, "offset");
        if (got_q.size() > 0) begin
`ifdef READOUT_RX_IQ_INTEG_OFFSET_EN
            check("offset_sat_i", got_q[0].i, 32767);
`else
            check("offset_ignored_i", got_q[0].i, 32000);
`endif
            check("offset_q", got_q[0].q, 1000);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/readout_rx_iq_integrator.md
READOUT_RX_IQ_INTEGRATOR -- requirements
Module: readout_rx_iq_integrator

Interface
REQ-001 Parameter DATA_WIDTH, default 16: width of signed I/Q samples, in and out.
REQ-002 Parameter LOG2_WIN_MAX, default 8: maximum window length is 2^LOG2_WIN_MAX samples.
REQ-003 Parameter ACC_WIDTH, default DATA_WIDTH+LOG2_WIN_MAX: width of the per-lane accumulator.
REQ-004 Parameter NUM_WIN_WIDTH, default 16: width of the windows-per-measurement count.
REQ-005 Port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-006 Port rst, input, 1: reset; asynchronous, active-low.
REQ-007 Port cfg_wr_en, input, 1: configuration write strobe.
REQ-008 Port cfg_wr_addr, input, 2: configuration register address.
REQ-009 Port cfg_wr_data, input, 16: configuration write data.
REQ-010 Port meas_start, input, 1: single-cycle request to start one measurement.
REQ-011 Port valid_in, input, 1: qualifies i_in and q_in.
REQ-012 Port i_in and q_in, input, DATA_WIDTH each: demodulated two's-complement samples.
REQ-013 Port start_count, output, 1: one-cycle pulse to the state decision unit.
REQ-014 Port finish_count, output, 1: one-cycle pulse to the state decision unit.
REQ-015 Port valid_out, output, 1: qualifies i_out and q_out.
REQ-016 Port i_out and q_out, output, DATA_WIDTH each: signed window averages.
REQ-017 Port busy, output, 1: high whenever the state is not IDLE.

Function
REQ-018 Configuration registers SHALL be addressed as follows.
- Address 0: log2_win, cfg_wr_data[3:0]; values above LOG2_WIN_MAX are clamped to LOG2_WIN_MAX.
- Address 1: num_win; a value of 0 is treated as 1.
- Addresses 2 and 3: see REQ-031.
REQ-019 Configuration writes SHALL take effect only in IDLE; writes in any other state are discarded.
REQ-020 The state machine SHALL have three states: IDLE, INTEG and FLUSH.
- IDLE to INTEG on meas_start.
- INTEG to FLUSH on the last sample of window num_win-1.
- FLUSH to IDLE after one cycle.
REQ-021 start_count SHALL pulse for one cycle, in the cycle after the accepted meas_start. Accumulators, sample counter and window counter clear on that edge.
REQ-022 meas_start SHALL be ignored while the state is INTEG or FLUSH.
REQ-023 In INTEG, each valid_in sample SHALL be sign-extended and added to its lane accumulator. Cycles without valid_in leave all state unchanged.
REQ-024 When the sample counter reaches 2^log2_win-1 with valid_in high:
- valid_out is high on the next cycle;
- i_out and q_out equal (accumulator + current sample) arithmetically shifted right by log2_win, truncated to DATA_WIDTH;
- the accumulators restart from 0 and the window counter increments.
REQ-025 With log2_win=0, every valid sample SHALL pass through with one cycle of latency.
REQ-026 finish_count SHALL pulse in FLUSH, exactly one cycle after the final valid_out. It never coincides with valid_out.
REQ-027 valid_in SHALL be ignored in IDLE and in FLUSH.
REQ-028 i_out and q_out SHALL hold their last value when valid_out is low.

Reset
REQ-029 While rst is low, the following SHALL hold:
- state is IDLE;
- all outputs are 0;
- accumulators and counters are 0;
- log2_win=4, num_win=1, offsets 0.
REQ-030 Reset asserted mid-measurement SHALL abort the measurement with no finish_count, and the first clock edge after release starts from IDLE.

Configuration
REQ-031 With macro READOUT_RX_IQ_INTEG_OFFSET_EN defined:
- addresses 2 and 3 hold signed DATA_WIDTH I and Q offsets;
- each offset is subtracted from the averaged value;
- the result saturates to the signed DATA_WIDTH range.
Without the macro, writes to addresses 2 and 3 are discarded and outputs are unmodified averages.
REQ-032 Output latency SHALL be identical with and without READOUT_RX_IQ_INTEG_OFFSET_EN.

Structure
REQ-033 Package readout_rx_pkg SHALL hold:
- the state enum (IDLE/INTEG/FLUSH);
- the configuration address constants;
- the reset defaults for log2_win and num_win.
REQ-034 One sub-module, readout_rx_iq_integ_lane, SHALL be instantiated twice (I and Q). It holds the accumulate, shift, offset and saturate logic. The FSM and counters stay in the top module.

Verification
REQ-035 Default config (log2_win=4, num_win=1); meas_start, then 16 valid samples of I=+100, Q=-100.
- valid_out one cycle after the 16th sample, with i_out=100 and q_out=-100;
- finish_count on the next cycle.
REQ-036 log2_win=2, num_win=3; samples I=1,2,3,4 | 4,4,4,4 | -8,-8,-8,-7.
- three valid_out pulses carrying i_out = 2, 4, -8 (the last is floor of -31/4);
- exactly one finish_count, after the third pulse.
REQ-037 valid_in toggled every other cycle during a window.
- averages and pulse count identical to the contiguous case;
- valid_out one cycle after the last valid sample.
REQ-038 meas_start and a cfg write to address 0 issued mid-measurement.
- both are ignored; no second start_count;
- log2_win is unchanged at the next measurement.
REQ-039 rst driven low after 7 of 16 samples, then released.
- all outputs are 0 and busy=0, with no finish_count;
- a new measurement yields correct averages.
REQ-040 With READOUT_RX_IQ_INTEG_OFFSET_EN defined, I offset=-32768 and average I=+32000.
- i_out saturates to +32767.
